// File: rtl/ctrl_decode_stage_pkg.sv
// Shared constants and the decoded control bundle for the decode stage.
package ctrl_dec_pkg;

  localparam int unsigned ILEN    = 32;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned MREG_W  = 3;
  localparam int unsigned ICNT_W  = 8;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_FW     = 7'd25;
  localparam logic [6:0] OP_ADDIW  = 7'd27;
  localparam logic [6:0] OP_MREG   = 7'd30;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_RTYPE  = 7'd51;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JAL    = 7'd111;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_NOT = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 4'd6;
  localparam logic [ALUOP_W-1:0] ALU_SRL = 4'd7;
  localparam logic [ALUOP_W-1:0] ALU_SRA = 4'd8;

  typedef struct packed {
    logic               reg_write;
    logic               alu_src;
    logic               mem_write;
    logic               mem_to_reg;
    logic               jump;
    logic               ble;
    logic               imme;
    logic               pl_done;
    logic               fw_ld;
    logic               mem_sel;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// Input/output stream handshake of the decode stage; slave = stage side.
interface ctrl_decode_stage_if
  import ctrl_dec_pkg::*;
();
  logic            in_valid;
  logic [ILEN-1:0] in_instr;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [ILEN-1:0] out_instr;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_instr
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_instr
  );
endinterface

// File: rtl/ctrl_decode_comb.sv
// Purely combinational instruction decoder: instr -> control bundle,
// plus the master-control update request for opcode 30.
module ctrl_decode_comb
  import ctrl_dec_pkg::*;
(
  input  logic [ILEN-1:0]   instr,
  output ctrl_bundle_t      ctrl,
  output logic              mreg_we,
  output logic [MREG_W-1:0] mreg_val
);
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign func3       = instr[14:12];
  assign func7       = instr[31:25];
  assign unused_bits = ^{instr[24:15], instr[11:7]};

  always_comb begin
    ctrl     = '0;
    mreg_we  = 1'b0;
    mreg_val = '0;
    case (opcode)
      OP_ADDIW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.imme       = 1'b1;
      end
      OP_IMM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.imme       = 1'b1;
        case (func3)
          3'b001:  ctrl.alu_op = ALU_SLL;
          3'b100:  ctrl.alu_op = ALU_NOT;
          3'b101: begin
            if (func7[6:1] == 6'b000000)      ctrl.alu_op = ALU_SRL;
            else if (func7[6:1] == 6'b010000) ctrl.alu_op = ALU_SRA;
            else                              ctrl.alu_op = ALU_ADD;
          end
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_RTYPE: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        if (func7 == 7'h00) begin
          case (func3)
            3'b110:  ctrl.alu_op = ALU_OR;
            3'b111:  ctrl.alu_op = ALU_AND;
            default: ctrl.alu_op = ALU_ADD;
          endcase
        end else if (func7 == 7'h20) begin
          ctrl.alu_op = ALU_SUB;
        end
      end
      OP_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.mem_sel   = (func3 == 3'b111);
      end
      OP_BRANCH: ctrl.ble = 1'b1;
      OP_LOAD: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imme      = 1'b1;
        ctrl.mem_sel   = (func3 == 3'b111);
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
      end
      OP_FW: begin
        if (func3 == 3'b000) begin
          ctrl.fw_ld     = 1'b1;
          ctrl.reg_write = 1'b1;
        end else if (func3 == 3'b001) begin
          ctrl.pl_done = 1'b1;
        end
      end
      OP_MREG: begin
        mreg_we  = 1'b1;
        mreg_val = (func3 == 3'b111) ? '0 : func3;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered decode stage with 2-entry skid buffer, sticky done latch and
// master-control register. Define CTRL_DEC_ILLEGAL_CNT_EN for illegal_cnt.
module ctrl_decode_stage
  import ctrl_dec_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  ctrl_decode_stage_if.slave bus,
  output logic               RegWrite,
  output logic               ALUSrc,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               Jump,
  output logic               ble,
  output logic               imme,
  output logic               PL_done,
  output logic               FW_ld,
  output logic               mem_sel,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [MREG_W-1:0]  master_reg,
  output logic               done,
  input  logic               restart,
  output logic               illegal,
  output logic [ICNT_W-1:0]  illegal_cnt
);
  ctrl_bundle_t      in_ctrl, main_ctrl, skid_ctrl;
  logic              in_mreg_we;
  logic [MREG_W-1:0] in_mreg_val;
  logic [ILEN-1:0]   main_instr, skid_instr;
  logic              main_vld, skid_vld, skid_vld_n;
  logic              rdy_q, done_q, done_n;
  logic [MREG_W-1:0] mreg_q;
  logic              accept, fire;

  ctrl_decode_comb u_dec (
    .instr    (bus.in_instr),
    .ctrl     (in_ctrl),
    .mreg_we  (in_mreg_we),
    .mreg_val (in_mreg_val)
  );

  assign accept = bus.in_valid && rdy_q;
  assign fire   = main_vld && bus.out_ready;

  // in_ready is registered, so it is derived from next-cycle skid/done state.
  always_comb begin
    skid_vld_n = skid_vld;
    if (!main_vld || fire) skid_vld_n = 1'b0;
    else if (accept)       skid_vld_n = 1'b1;
    done_n = done_q;
    if (accept && in_ctrl.pl_done) done_n = 1'b1;
    else if (restart)              done_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld   <= 1'b0;
      main_instr <= '0;
      main_ctrl  <= '0;
      skid_vld   <= 1'b0;
      skid_instr <= '0;
      skid_ctrl  <= '0;
      rdy_q      <= 1'b1;
      done_q     <= 1'b0;
      mreg_q     <= '0;
    end else begin
      if (!main_vld || fire) begin
        if (skid_vld) begin
          main_vld   <= 1'b1;
          main_instr <= skid_instr;
          main_ctrl  <= skid_ctrl;
        end else begin
          main_vld <= accept;
          if (accept) begin
            main_instr <= bus.in_instr;
            main_ctrl  <= in_ctrl;
          end
        end
      end else if (accept) begin
        skid_instr <= bus.in_instr;
        skid_ctrl  <= in_ctrl;
      end
      skid_vld <= skid_vld_n;
      done_q   <= done_n;
      rdy_q    <= !skid_vld_n && !done_n;
      if (accept && in_mreg_we) mreg_q <= in_mreg_val;
    end
  end

`ifdef CTRL_DEC_ILLEGAL_CNT_EN
  logic [ICNT_W-1:0] icnt_q;

  always_ff @(posedge clk) begin
    if (rst)                                             icnt_q <= '0;
    else if (accept && in_ctrl.illegal && icnt_q != '1) icnt_q <= icnt_q + ICNT_W'(1);
  end

  assign illegal_cnt = icnt_q;
`else
  assign illegal_cnt = '0;
`endif

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = main_vld;
  assign bus.out_instr = main_instr;
  assign RegWrite      = main_ctrl.reg_write;
  assign ALUSrc        = main_ctrl.alu_src;
  assign MemWrite      = main_ctrl.mem_write;
  assign MemtoReg      = main_ctrl.mem_to_reg;
  assign Jump          = main_ctrl.jump;
  assign ble           = main_ctrl.ble;
  assign imme          = main_ctrl.imme;
  assign PL_done       = main_ctrl.pl_done;
  assign FW_ld         = main_ctrl.fw_ld;
  assign mem_sel       = main_ctrl.mem_sel;
  assign ALUop         = main_ctrl.alu_op;
  assign illegal       = main_ctrl.illegal;
  assign master_reg    = mreg_q;
  assign done          = done_q;
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed vector bench for ctrl_decode_stage: decode table plus
// hand-written skid, master_reg, done/restart, illegal and reset sequences.
module tb_ctrl_decode_stage;
  logic       clk = 1'b0;
  logic       rst;
  logic       restart;
  logic       RegWrite, ALUSrc, MemWrite, MemtoReg, Jump, ble, imme;
  logic       PL_done, FW_ld, mem_sel, done, illegal;
  logic [3:0] ALUop;
  logic [2:0] master_reg;
  logic [7:0] illegal_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  ctrl_decode_stage_if bus();

  ctrl_decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .RegWrite    (RegWrite),
    .ALUSrc      (ALUSrc),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .Jump        (Jump),
    .ble         (ble),
    .imme        (imme),
    .PL_done     (PL_done),
    .FW_ld       (FW_ld),
    .mem_sel     (mem_sel),
    .ALUop       (ALUop),
    .master_reg  (master_reg),
    .done        (done),
    .restart     (restart),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  // flags: RegWrite ALUSrc MemWrite MemtoReg Jump ble imme PL_done FW_ld mem_sel
  typedef struct {
    logic [31:0] instr;
    logic [9:0]  flags;
    logic [3:0]  alu;
    logic        ill;
  } vec_t;

  vec_t tab[$];

  function automatic logic [14:0] ctl_now();
    return {RegWrite, ALUSrc, MemWrite, MemtoReg, Jump, ble, imme,
            PL_done, FW_ld, mem_sel, ALUop, illegal};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    bus.in_valid = 1'b1;
    bus.in_instr = w;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    tab.push_back('{32'h0017879B, 10'b1101001000, 4'd0, 1'b0}); // addiw
    tab.push_back('{32'h00279793, 10'b1101001000, 4'd6, 1'b0}); // slli
    tab.push_back('{32'h00F707B3, 10'b1001000000, 4'd0, 1'b0}); // add
    tab.push_back('{32'hFEC42783, 10'b1100001000, 4'd0, 1'b0}); // lw
    tab.push_back('{32'hFEC47783, 10'b1100001001, 4'd0, 1'b0}); // load f3=7
    tab.push_back('{32'h00F72023, 10'b0110000000, 4'd0, 1'b0}); // sw
    tab.push_back('{32'h00F77023, 10'b0110000001, 4'd0, 1'b0}); // store f3=7
    tab.push_back('{32'h00E7D463, 10'b0000010000, 4'd0, 1'b0}); // branch
    tab.push_back('{32'h0000006F, 10'b1000100000, 4'd0, 1'b0}); // jal
    tab.push_back('{32'h00000019, 10'b1000000010, 4'd0, 1'b0}); // fw_ld
    tab.push_back('{32'h00002019, 10'b0000000000, 4'd0, 1'b0}); // op25 f3=2
    tab.push_back('{32'h40F707B3, 10'b1001000000, 4'd1, 1'b0}); // sub
    tab.push_back('{32'h00F767B3, 10'b1001000000, 4'd3, 1'b0}); // or
    tab.push_back('{32'h00F777B3, 10'b1001000000, 4'd2, 1'b0}); // and
    tab.push_back('{32'h02F707B3, 10'b1001000000, 4'd0, 1'b0}); // func7=0x01
    tab.push_back('{32'h00F717B3, 10'b1001000000, 4'd0, 1'b0}); // r f3=1
    tab.push_back('{32'h0017D793, 10'b1101001000, 4'd7, 1'b0}); // srli
    tab.push_back('{32'h0217D793, 10'b1101001000, 4'd7, 1'b0}); // srli func7=0x01
    tab.push_back('{32'h4017D793, 10'b1101001000, 4'd8, 1'b0}); // srai
    tab.push_back('{32'h4217D793, 10'b1101001000, 4'd8, 1'b0}); // srai func7=0x21
    tab.push_back('{32'h0417D793, 10'b1101001000, 4'd0, 1'b0}); // f3=5 func7=0x02
    tab.push_back('{32'hFFF7C793, 10'b1101001000, 4'd4, 1'b0}); // xori
    tab.push_back('{32'h0007A793, 10'b1101001000, 4'd0, 1'b0}); // slti
    tab.push_back('{32'h00A00513, 10'b1101001000, 4'd0, 1'b0}); // addi
    tab.push_back('{32'h0000201E, 10'b0000000000, 4'd0, 1'b0}); // master ctrl

    rst = 1'b1; restart = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // reset state
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_ctl", 32'(ctl_now()), 32'd0);
    check("rst_master", 32'(master_reg), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_icnt", 32'(illegal_cnt), 32'd0);

    // decode table, streamed back to back
    foreach (tab[i]) begin
      check("tbl_in_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_instr = tab[i].instr;
      tick();
      check("tbl_valid", 32'(bus.out_valid), 32'd1);
      check("tbl_instr", bus.out_instr, tab[i].instr);
      check("tbl_ctl", 32'(ctl_now()), 32'({tab[i].flags, tab[i].alu, tab[i].ill}));
    end
    bus.in_valid = 1'b0;
    tick();
    check("drain_valid", 32'(bus.out_valid), 32'd0);

    // skid: stall three cycles with input pending
    send(32'hFEC42783);
    check("skid_a", bus.out_instr, 32'hFEC42783);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h00F707B3;
    tick();
    check("skid_hold1", bus.out_instr, 32'hFEC42783);
    check("skid_rdy1", 32'(bus.in_ready), 32'd0);
    bus.in_instr = 32'h0017879B;
    tick();
    check("skid_hold2", bus.out_instr, 32'hFEC42783);
    check("skid_rdy2", 32'(bus.in_ready), 32'd0);
    tick();
    check("skid_hold3", bus.out_instr, 32'hFEC42783);
    check("skid_vld3", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    check("skid_b", bus.out_instr, 32'h00F707B3);
    check("skid_b_ctl", 32'(ctl_now()), 32'({10'b1001000000, 4'd0, 1'b0}));
    check("skid_rdy_back", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("skid_c", bus.out_instr, 32'h0017879B);
    check("skid_c_vld", 32'(bus.out_valid), 32'd1);
    tick();
    check("skid_empty", 32'(bus.out_valid), 32'd0);

    // master_reg
    send(32'h0000401E);
    check("mreg_4", 32'(master_reg), 32'd4);
    check("mreg_ctl", 32'(ctl_now()), 32'd0);
    send(32'h00F707B3);
    check("mreg_keep", 32'(master_reg), 32'd4);
    send(32'h0000701E);
    check("mreg_7_to_0", 32'(master_reg), 32'd0);

    // restart without done has no effect
    restart = 1'b1; tick(); restart = 1'b0;
    check("rs_idle_done", 32'(done), 32'd0);
    check("rs_idle_rdy", 32'(bus.in_ready), 32'd1);

    // done latch blocks intake until restart
    bus.in_valid = 1'b1; bus.in_instr = 32'h00001019;
    tick();
    check("done_set", 32'(done), 32'd1);
    check("done_rdy", 32'(bus.in_ready), 32'd0);
    check("done_plflag", 32'(PL_done), 32'd1);
    bus.in_instr = 32'h0017879B;
    tick();
    check("done_drained", 32'(bus.out_valid), 32'd0);
    check("done_blocked", 32'(bus.in_ready), 32'd0);
    tick();
    check("done_sticky", 32'(done), 32'd1);
    restart = 1'b1; tick(); restart = 1'b0;
    check("done_clr", 32'(done), 32'd0);
    check("done_rdy_back", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("done_next_word", bus.out_instr, 32'h0017879B);
    check("done_next_vld", 32'(bus.out_valid), 32'd1);

    // restart together with the output handshake of the done word
    send(32'h00001019);
    check("done2_set", 32'(done), 32'd1);
    restart = 1'b1; tick(); restart = 1'b0;
    check("done2_clr", 32'(done), 32'd0);
    check("done2_out", 32'(bus.out_valid), 32'd0);
    check("done2_rdy", 32'(bus.in_ready), 32'd1);

    // illegal opcodes, counter saturation
    check("icnt_pre", 32'(illegal_cnt), 32'd0);
    bus.in_valid = 1'b1; bus.in_instr = 32'h0000007F;
    for (int i = 0; i < 300; i++) begin
      tick();
      check("ill_ctl", 32'(ctl_now()), 32'd1);
`ifdef CTRL_DEC_ILLEGAL_CNT_EN
      check("ill_cnt", 32'(illegal_cnt), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
`else
      check("ill_cnt", 32'(illegal_cnt), 32'd0);
`endif
    end
    bus.in_valid = 1'b0;
    tick();

    // reset with both registers full
    bus.out_ready = 1'b0;
    send(32'h0000301E);
    send(32'h00001019);
    check("full_rdy", 32'(bus.in_ready), 32'd0);
    check("full_master", 32'(master_reg), 32'd3);
    check("full_done", 32'(done), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mrst_vld", 32'(bus.out_valid), 32'd0);
    check("mrst_rdy", 32'(bus.in_ready), 32'd1);
    check("mrst_master", 32'(master_reg), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_instr", bus.out_instr, 32'd0);
    check("mrst_icnt", 32'(illegal_cnt), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    check("mrst_no_leftover", 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
